// File: rtl/arb_rr_mux4.sv
// Round-robin arbiter for four requesters sharing a 4:1 one-bit mux.
// Drives the mux select from the current owner and revokes grants held too long under contention.
module arb_rr_mux4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic       f,
    output logic       preempt
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;

    logic             found_all, found_oth;
    logic [1:0]       win_all, win_oth;

    // Search ptr+1, ptr+2, ptr+3, then ptr; the "other" search skips ptr itself.
    always_comb begin
        found_all = 1'b0;
        found_oth = 1'b0;
        win_all   = ptr_q;
        win_oth   = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!found_all && req[ptr_q + 2'(i)]) begin
                found_all = 1'b1;
                win_all   = ptr_q + 2'(i);
            end
            if (i < 4 && !found_oth && req[ptr_q + 2'(i)]) begin
                found_oth = 1'b1;
                win_oth   = ptr_q + 2'(i);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found_all) begin
                    state_d = BUSY;
                    gnt_d   = 4'(1) << win_all;
                    sel_d   = win_all;
                    ptr_d   = win_all;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                // In BUSY ptr_q equals the owner, so the "other" search excludes it.
                if (!req[sel_q]) begin
                    if (found_oth) begin
                        gnt_d = 4'(1) << win_oth;
                        sel_d = win_oth;
                        ptr_d = win_oth;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q >= HOLD_LAST && found_oth) begin
                    gnt_d     = 4'(1) << win_oth;
                    sel_d     = win_oth;
                    ptr_d     = win_oth;
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign valid   = valid_q;
    assign preempt = preempt_q;
    // Data path is purely combinational; only the select is registered.
    assign f       = valid_q & d[sel_q];

endmodule

// File: tb/tb_arb_rr_mux4.sv
// Directed bench for arb_rr_mux4 with MAX_HOLD = 2 and hand-computed expectations.
module tb_arb_rr_mux4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       s1, s0, valid, f, preempt;

    int n_checks;
    int n_fail;

    arb_rr_mux4 #(.MAX_HOLD(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .valid   (valid),
        .f       (f),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                             input logic e_valid, input logic e_f, input logic e_p);
        check({tag, ".gnt"},     8'(gnt),         8'(e_gnt));
        check({tag, ".sel"},     8'({s1, s0}),    8'(e_sel));
        check({tag, ".valid"},   8'(valid),       8'(e_valid));
        check({tag, ".f"},       8'(f),           8'(e_f));
        check({tag, ".preempt"}, 8'(preempt),     8'(e_p));
        check({tag, ".onehot"},  8'($onehot0(gnt)), 8'(1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         exp_own [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic       exp_p   [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b0000;
        step();
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // All requesting: two cycles per owner, preempt at each handover
        req = 4'b1111;
        d   = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            step();
            check_out("rr", 4'(1) << exp_own[i], 2'(exp_own[i]), 1'b1,
                      (exp_own[i] % 2) == 0, exp_p[i]);
        end

        // Lone requester 2 keeps grant indefinitely
        req = 4'b0100;
        step();
        check_out("lone_take", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_out("lone_hold", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        end

        // Late contender after saturation triggers immediate preempt
        req = 4'b0110;
        step();
        check_out("late_preempt", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0 | 1'b1);
        step();
        check_out("after_preempt", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);

        // Owner 1 drops with 0 and 3 waiting: 3 is next, no bubble
        d = 4'b1000;
        #1;
        check("f_owner1", 8'(f), 8'(0));
        req = 4'b1001;
        step();
        check_out("drop_handover", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);

        // Reset mid-grant, then requester 0 wins first
        rst = 1'b1;
        step();
        check_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("post_reset", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Owner 2 drops exactly at hold expiry: plain handover, no preempt
        d   = 4'b0100;
        req = 4'b0100;
        step();
        check_out("to_2", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        step();
        check_out("hold_2", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        req = 4'b0001;
        step();
        check_out("drop_at_expiry", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Release to idle keeps the last select, f forced low
        req = 4'b0100;
        step();
        check_out("to_2b", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        check_out("to_idle", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
